// File: rtl/uart_pkg.sv
// Types and defaults shared by the UART receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEF = 16;
  localparam int unsigned DATA_WIDTH_DEF   = 8;

endpackage

// File: rtl/uart_rx_sipo.sv
// Serial-in/parallel-out register; bits enter at the MSB so an LSB-first frame lands in order.
module uart_rx_sipo #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_shift_en,
  input  logic                  i_serial_in,
  output logic [DATA_WIDTH-1:0] o_parallel_out
);

  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_shift_en) begin
      r_data <= {i_serial_in, r_data[DATA_WIDTH-1:1]};
    end
  end

  assign o_parallel_out = r_data;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronized serial line to parallel byte with even-parity and framing checks.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rx_in,
  input  logic                  i_parity_enable,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_valid,
  output logic                  o_parity_error,
  output logic                  o_framing_error,
  output logic                  o_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

  logic                  r_sync1, r_sync2, w_rx_s;
  uart_state_e           r_state, w_state_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic [IdxW-1:0]       r_bit_idx, w_bit_idx_d;
  logic                  r_par_en, w_par_en_d;
  logic                  r_par, w_par_d;
  logic                  w_shift_en;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] r_data_out, w_data_d;
  logic                  r_valid, w_valid_d;
  logic                  r_perr, w_perr_d;
  logic                  r_ferr, w_ferr_d;
  logic                  r_busy, w_busy_d;
  logic                  w_half, w_full, w_par_ok;

  // rx_in is asynchronous to clk; sync flops reset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s   = r_sync2;
  assign w_half   = (r_cnt == CntHalf);
  assign w_full   = (r_cnt == CntFull);
  assign w_par_ok = !r_par_en || (r_par == ^w_shift);

  uart_rx_sipo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sipo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_shift_en    (w_shift_en),
    .i_serial_in   (w_rx_s),
    .o_parallel_out(w_shift)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      WAIT_IDLE: if (w_rx_s) w_state_d = IDLE;
      IDLE:      if (!w_rx_s) w_state_d = START;
      START:     if (w_half) w_state_d = w_rx_s ? IDLE : DATA;
      DATA: begin
        if (w_full && (r_bit_idx == IdxLast)) w_state_d = r_par_en ? PARITY : STOP;
      end
      PARITY:    if (w_full) w_state_d = STOP;
      // A low stop bit may be a line break, so wait for the line to return high.
      STOP:      if (w_full) w_state_d = w_rx_s ? IDLE : WAIT_IDLE;
      default:   w_state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_d     = r_cnt + 1'b1;
    w_bit_idx_d = r_bit_idx;
    w_par_en_d  = r_par_en;
    w_par_d     = r_par;
    w_shift_en  = 1'b0;
    w_data_d    = r_data_out;
    w_valid_d   = 1'b0;
    w_perr_d    = 1'b0;
    w_ferr_d    = 1'b0;
    w_busy_d    = (w_state_d != IDLE) && (w_state_d != WAIT_IDLE);
    unique case (r_state)
      WAIT_IDLE: w_cnt_d = '0;
      IDLE: begin
        w_cnt_d     = '0;
        w_bit_idx_d = '0;
        if (!w_rx_s) w_par_en_d = i_parity_enable;
      end
      START: begin
        if (w_half) begin
          w_cnt_d     = '0;
          w_bit_idx_d = '0;
        end
      end
      DATA: begin
        if (w_full) begin
          w_shift_en  = 1'b1;
          w_cnt_d     = '0;
          w_bit_idx_d = r_bit_idx + 1'b1;
        end
      end
      PARITY: begin
        if (w_full) begin
          w_par_d = w_rx_s;
          w_cnt_d = '0;
        end
      end
      STOP: begin
        if (w_full) begin
          w_cnt_d = '0;
          if (!w_rx_s) begin
            w_ferr_d = 1'b1;
          end else if (!w_par_ok) begin
            w_perr_d = 1'b1;
          end else begin
            w_valid_d = 1'b1;
            w_data_d  = w_shift;
          end
        end
      end
      default: w_cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_par_en   <= 1'b0;
      r_par      <= 1'b0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_bit_idx  <= w_bit_idx_d;
      r_par_en   <= w_par_en_d;
      r_par      <= w_par_d;
      r_data_out <= w_data_d;
      r_valid    <= w_valid_d;
      r_perr     <= w_perr_d;
      r_ferr     <= w_ferr_d;
      r_busy     <= w_busy_d;
    end
  end

  assign o_data_out      = r_data_out;
  assign o_data_valid    = r_valid;
  assign o_parity_error  = r_perr;
  assign o_framing_error = r_ferr;
  assign o_busy          = r_busy;

endmodule
